// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding main-memory controller shared by the I-cache and D-cache miss paths.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the D-side has fixed priority over the I-side.
module mem_arbiter #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int MEM_LAT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ic_req,
   input  logic [AW-1:0] ic_addr,
   output logic          ic_done,
   output logic [DW-1:0] ic_data,
   input  logic          dc_req,
   input  logic          dc_wr,
   input  logic [AW-1:0] dc_addr,
   input  logic [DW-1:0] dc_wdata,
   output logic          dc_done,
   output logic [DW-1:0] dc_rdata,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_stall,
   output logic          busy,
   output logic          owner
);

   localparam int CW = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr_q, wr_d;
   logic          owner_q, owner_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] icData_q, icData_d;
   logic [DW-1:0] dcRdata_q, dcRdata_d;
   logic          icDone_q, icDone_d;
   logic          dcDone_q, dcDone_d;
   logic          memRd_q, memRd_d;
   logic          memWr_q, memWr_d;
   logic          busy_q, busy_d;
   logic          grantD;

`ifdef MEM_ARB_RR_EN
   logic lastD_q;

   // On a tie the side that did not win last time gets the grant.
   always_comb begin
      if (dc_req && ic_req) begin
         grantD = ~lastD_q;
      end else begin
         grantD = dc_req;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lastD_q <= 1'b0;
      end else if ((state_q == IDLE) && (dc_req || ic_req)) begin
         lastD_q <= grantD;
      end
   end
`else
   assign grantD = dc_req;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      icData_d  = icData_q;
      dcRdata_d = dcRdata_q;
      icDone_d  = 1'b0;
      dcDone_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (dc_req || ic_req) begin
               state_d = ISSUE;
               owner_d = grantD;
               if (grantD) begin
                  addr_d  = dc_addr;
                  wdata_d = dc_wdata;
                  wr_d    = dc_wr;
               end else begin
                  addr_d  = ic_addr;
                  wdata_d = '0;
                  wr_d    = 1'b0;
               end
            end
         end
         ISSUE: begin
            if (!mem_stall) begin
               state_d = WAIT;
               cnt_d   = CW'(MEM_LAT - 1);
            end
         end
         WAIT: begin
            // Done pulse and read data are registered here so they appear together in DONE.
            if (cnt_q == '0) begin
               state_d = DONE;
               if (owner_q) begin
                  dcDone_d = 1'b1;
                  if (!wr_q) begin
                     dcRdata_d = mem_rdata;
                  end
               end else begin
                  icDone_d = 1'b1;
                  icData_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      memRd_d = (state_d == ISSUE) && !wr_d;
      memWr_d = (state_d == ISSUE) && wr_d;
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         owner_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         icData_q  <= '0;
         dcRdata_q <= '0;
         icDone_q  <= 1'b0;
         dcDone_q  <= 1'b0;
         memRd_q   <= 1'b0;
         memWr_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         icData_q  <= icData_d;
         dcRdata_q <= dcRdata_d;
         icDone_q  <= icDone_d;
         dcDone_q  <= dcDone_d;
         memRd_q   <= memRd_d;
         memWr_q   <= memWr_d;
         busy_q    <= busy_d;
      end
   end

   assign ic_done   = icDone_q;
   assign ic_data   = icData_q;
   assign dc_done   = dcDone_q;
   assign dc_rdata  = dcRdata_q;
   assign mem_rd    = memRd_q;
   assign mem_wr    = memWr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = busy_q;
   assign owner     = owner_q;

endmodule
